// File: rtl/mae_dsp_model_if.sv
// Operand, control and result bundle of the MAE DSP slice.
// The member names match the slice's primitive pin names.
interface mae_dsp_model_if;
  logic signed [17:0] A;
  logic               A_EN;
  logic               A_SRST_N;
  logic signed [17:0] B;
  logic               B_EN;
  logic               B_SRST_N;
  logic signed [39:0] C;
  logic               C_EN;
  logic               C_SRST_N;
  logic               ACC_LOAD;
  logic               P_EN;
  logic               P_SRST_N;
  logic signed [47:0] P;
  logic               P_OVF;

  modport master (
    output A, A_EN, A_SRST_N, B, B_EN, B_SRST_N, C, C_EN, C_SRST_N,
           ACC_LOAD, P_EN, P_SRST_N,
    input  P, P_OVF
  );

  modport slave (
    input  A, A_EN, A_SRST_N, B, B_EN, B_SRST_N, C, C_EN, C_SRST_N,
           ACC_LOAD, P_EN, P_SRST_N,
    output P, P_OVF
  );
endinterface

// File: rtl/mae_dsp_model.sv
// Cycle-accurate model of the MAE DSP slice: 18x18 signed multiply with
// optional input/C/P registers and a configurable post-adder/accumulator.
module mae_dsp_model #(
  parameter int unsigned BYPASS_A   = 0,
  parameter int unsigned BYPASS_B   = 0,
  parameter int unsigned BYPASS_C   = 0,
  parameter int unsigned BYPASS_P   = 0,
  parameter int unsigned POST_ADDER = 0
) (
  input logic            CLK,
  input logic            SRST,
  mae_dsp_model_if.slave dsp
);

  if ((POST_ADDER >= 2) && (BYPASS_P != 0)) begin : g_cfg_err
    $error("mae_dsp_model: accumulate modes require the P register (BYPASS_P=0)");
  end

  logic signed [17:0] a_q, b_q, a_int, b_int;
  logic signed [39:0] c_q, c_int;
  logic               ld_q, ld;
  logic signed [35:0] prod;
  logic signed [47:0] prod48, c48, acc_sum;
  logic signed [47:0] p_q, p_d;
  logic               ovf_q, ovf_d;

  // Operand registers; ACC_LOAD rides with A so LD stays aligned with its operands.
  always_ff @(posedge CLK) begin
    if (SRST || !dsp.A_SRST_N) begin
      a_q  <= '0;
      ld_q <= 1'b0;
    end else if (dsp.A_EN) begin
      a_q  <= dsp.A;
      ld_q <= dsp.ACC_LOAD;
    end

    if (SRST || !dsp.B_SRST_N) b_q <= '0;
    else if (dsp.B_EN)         b_q <= dsp.B;

    if (SRST || !dsp.C_SRST_N) c_q <= '0;
    else if (dsp.C_EN)         c_q <= dsp.C;
  end

  assign a_int = (BYPASS_A != 0) ? dsp.A        : a_q;
  assign b_int = (BYPASS_B != 0) ? dsp.B        : b_q;
  assign c_int = (BYPASS_C != 0) ? dsp.C        : c_q;
  assign ld    = (BYPASS_A != 0) ? dsp.ACC_LOAD : ld_q;

  always_comb begin
    prod    = a_int * b_int;
    prod48  = {{12{prod[35]}}, prod};
    c48     = {{8{c_int[39]}}, c_int};
    acc_sum = p_q + prod48;

    case (POST_ADDER)
      0:       p_d = prod48;
      1:       p_d = prod48 + c48;
      2:       p_d = ld ? prod48 : acc_sum;
      default: p_d = ld ? (prod48 + c48) : acc_sum;
    endcase

    // Overflow only on non-LD accumulate steps: like-signed operands, unlike-signed sum.
    ovf_d = ovf_q;
    if (dsp.P_EN) begin
      if (ld)
        ovf_d = 1'b0;
      else if ((prod48[47] == p_q[47]) && (acc_sum[47] != p_q[47]))
        ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (SRST || !dsp.P_SRST_N) begin
      p_q   <= '0;
      ovf_q <= 1'b0;
    end else if (dsp.P_EN) begin
      p_q   <= p_d;
      ovf_q <= ovf_d;
    end
  end

  assign dsp.P     = (BYPASS_P != 0) ? p_d : p_q;
  assign dsp.P_OVF = (POST_ADDER >= 2) ? ovf_q : 1'b0;

endmodule

// File: tb/tb_mae_dsp_model.sv
// Directed bench for mae_dsp_model: four instances cover registered mode 0,
// fully bypassed mode 1, registered accumulate (mode 2) and C-preload accumulate (mode 3).
module tb_mae_dsp_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2, rst3;
  int   checks = 0;
  int   errors = 0;

  mae_dsp_model_if if0 ();
  mae_dsp_model_if if1 ();
  mae_dsp_model_if if2 ();
  mae_dsp_model_if if3 ();

  mae_dsp_model #(.BYPASS_A(0), .BYPASS_B(0), .BYPASS_C(0), .BYPASS_P(0), .POST_ADDER(0))
    u0 (.CLK(clk), .SRST(rst0), .dsp(if0));
  mae_dsp_model #(.BYPASS_A(1), .BYPASS_B(1), .BYPASS_C(1), .BYPASS_P(1), .POST_ADDER(1))
    u1 (.CLK(clk), .SRST(rst1), .dsp(if1));
  mae_dsp_model #(.BYPASS_A(0), .BYPASS_B(0), .BYPASS_C(0), .BYPASS_P(0), .POST_ADDER(2))
    u2 (.CLK(clk), .SRST(rst2), .dsp(if2));
  mae_dsp_model #(.BYPASS_A(0), .BYPASS_B(0), .BYPASS_C(0), .BYPASS_P(0), .POST_ADDER(3))
    u3 (.CLK(clk), .SRST(rst3), .dsp(if3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    if0.A = 18'sd7; if0.B = 18'sd7; if0.C = '0; if0.ACC_LOAD = 1'b0;
    if0.A_EN = 1'b1; if0.B_EN = 1'b1; if0.C_EN = 1'b1; if0.P_EN = 1'b1;
    if0.A_SRST_N = 1'b1; if0.B_SRST_N = 1'b1; if0.C_SRST_N = 1'b1; if0.P_SRST_N = 1'b1;
    if1.A = 18'sd2; if1.B = 18'sd3; if1.C = 40'sd1; if1.ACC_LOAD = 1'b0;
    if1.A_EN = 1'b1; if1.B_EN = 1'b1; if1.C_EN = 1'b1; if1.P_EN = 1'b1;
    if1.A_SRST_N = 1'b1; if1.B_SRST_N = 1'b1; if1.C_SRST_N = 1'b1; if1.P_SRST_N = 1'b1;
    if2.A = 18'sd1; if2.B = 18'sd1; if2.C = '0; if2.ACC_LOAD = 1'b0;
    if2.A_EN = 1'b1; if2.B_EN = 1'b1; if2.C_EN = 1'b1; if2.P_EN = 1'b1;
    if2.A_SRST_N = 1'b1; if2.B_SRST_N = 1'b1; if2.C_SRST_N = 1'b1; if2.P_SRST_N = 1'b1;
    if3.A = 18'sd1; if3.B = 18'sd1; if3.C = 40'sd3; if3.ACC_LOAD = 1'b1;
    if3.A_EN = 1'b1; if3.B_EN = 1'b1; if3.C_EN = 1'b1; if3.P_EN = 1'b1;
    if3.A_SRST_N = 1'b1; if3.B_SRST_N = 1'b1; if3.C_SRST_N = 1'b1; if3.P_SRST_N = 1'b1;

    // Load nonzero state everywhere, then reset it away.
    tick; tick;
    chk("m0_pre_reset", if0.P, 48'd49);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    if2.A = '0; if2.B = '0; if3.A = '0; if3.B = '0; if3.C = '0; if3.ACC_LOAD = 1'b0;
    tick;
    chk("m0_reset_p", if0.P, 48'd0);
    chk("m2_reset_p", if2.P, 48'd0);
    chk("m3_reset_p", if3.P, 48'd0);
    chk("m0_ovf_const", {47'd0, if0.P_OVF}, 48'd0);
    chk("m1_bypass_in_reset", if1.P, 48'd7);

    // Fully bypassed mode 1 follows inputs combinationally.
    if1.A = 18'sd100; if1.B = 18'sd200; if1.C = -40'sd5;
    #1 chk("m1_c_neg", if1.P, 48'd19995);
    if1.C = 40'sd5;
    #1 chk("m1_c_pos", if1.P, 48'd20005);
    chk("m1_ovf_const", {47'd0, if1.P_OVF}, 48'd0);

    // Registered mode 0: two-cycle latency, back-to-back, enables, B clear, extremes.
    rst0 = 1'b0; if0.A = -18'sd4; if0.B = 18'sd3;
    if0.A = 18'sd3; if0.B = -18'sd4;
    tick; chk("m0_lat1", if0.P, 48'd0);
    if0.A = 18'sd5; if0.B = 18'sd7;
    tick; chk("m0_neg12", if0.P, 48'hFFFF_FFFF_FFF4);
    if0.A = -18'sd1; if0.B = -18'sd1;
    tick; chk("m0_b2b_35", if0.P, 48'd35);
    if0.A = 18'sd9; if0.B = 18'sd9; if0.A_EN = 1'b0; if0.B_EN = 1'b0;
    tick; chk("m0_b2b_1", if0.P, 48'd1);
    tick; chk("m0_en_hold", if0.P, 48'd1);
    if0.B_SRST_N = 1'b0;
    tick; chk("m0_bclr_lag", if0.P, 48'd1);
    tick; chk("m0_bclr", if0.P, 48'd0);
    if0.B_SRST_N = 1'b1; if0.A_EN = 1'b1; if0.B_EN = 1'b1;
    if0.A = 18'sh20000; if0.B = 18'sh1FFFF;
    tick;
    if0.B = 18'sh20000;
    tick; chk("m0_min_x_max", if0.P, 48'hFFFC_0002_0000);
    tick; chk("m0_min_x_min", if0.P, 48'h0004_0000_0000);

    // Mode 2 accumulate.
    rst2 = 1'b0; if2.A = 18'sd2; if2.B = 18'sd3; if2.ACC_LOAD = 1'b1;
    tick; chk("m2_e0", if2.P, 48'd0);
    if2.ACC_LOAD = 1'b0;
    tick; chk("m2_ld6", if2.P, 48'd6);
    tick; chk("m2_acc12", if2.P, 48'd12);
    tick; chk("m2_acc18", if2.P, 48'd18);
    tick; chk("m2_acc24", if2.P, 48'd24);
    if2.P_EN = 1'b0;
    tick; chk("m2_pen_hold", if2.P, 48'd24);
    if2.P_EN = 1'b1;
    tick; chk("m2_acc30", if2.P, 48'd30);
    rst2 = 1'b1;
    tick; chk("m2_srst_p", if2.P, 48'd0);
    chk("m2_srst_ovf", {47'd0, if2.P_OVF}, 48'd0);
    rst2 = 1'b0;
    tick; chk("m2_post_rst0", if2.P, 48'd0);
    tick; chk("m2_post_rst_acc", if2.P, 48'd6);
    if2.A_SRST_N = 1'b0;
    tick; chk("m2_aclr_lag", if2.P, 48'd12);
    if2.A_SRST_N = 1'b1; if2.A_EN = 1'b0;
    tick; chk("m2_aclr_zero_prod", if2.P, 48'd12);
    if2.A_EN = 1'b1; if2.A = 18'sd4; if2.ACC_LOAD = 1'b1;
    tick; chk("m2_ld_setup", if2.P, 48'd12);
    if2.ACC_LOAD = 1'b0; if2.P_SRST_N = 1'b0;
    tick; chk("m2_pclr_beats_ld", if2.P, 48'd0);
    if2.P_SRST_N = 1'b1;
    tick; chk("m2_after_pclr", if2.P, 48'd12);
    if2.ACC_LOAD = 1'b1; if2.A = 18'sd1; if2.B = 18'sd1;
    tick; chk("m2_acc24b", if2.P, 48'd24);
    if2.ACC_LOAD = 1'b0; if2.P_EN = 1'b0;
    tick; chk("m2_ld_lost_hold", if2.P, 48'd24);
    if2.P_EN = 1'b1;
    tick; chk("m2_ld_lost_acc", if2.P, 48'd25);

    // Mode 3 overflow: 2^34 per beat wraps after 8192 terms.
    rst3 = 1'b0; if3.A = 18'sh20000; if3.B = 18'sh20000; if3.C = '0; if3.ACC_LOAD = 1'b1;
    tick; chk("m3_e0", if3.P, 48'd0);
    if3.ACC_LOAD = 1'b0;
    tick; chk("m3_ld", if3.P, 48'h0004_0000_0000);
    repeat (8190) tick;
    chk("m3_prewrap_p", if3.P, 48'h7FFC_0000_0000);
    chk("m3_prewrap_ovf", {47'd0, if3.P_OVF}, 48'd0);
    tick;
    chk("m3_wrap_p", if3.P, 48'h8000_0000_0000);
    chk("m3_wrap_ovf", {47'd0, if3.P_OVF}, 48'd1);
    tick;
    chk("m3_sticky_p", if3.P, 48'h8004_0000_0000);
    chk("m3_sticky_ovf", {47'd0, if3.P_OVF}, 48'd1);
    if3.ACC_LOAD = 1'b1; if3.C = 40'sd5;
    tick;
    chk("m3_ldsetup_p", if3.P, 48'h8008_0000_0000);
    chk("m3_ldsetup_ovf", {47'd0, if3.P_OVF}, 48'd1);
    if3.ACC_LOAD = 1'b0;
    tick;
    chk("m3_ld_c_p", if3.P, 48'h0004_0000_0005);
    chk("m3_ld_clr_ovf", {47'd0, if3.P_OVF}, 48'd0);
    repeat (8190) tick;
    chk("m3_prewrap2_p", if3.P, 48'h7FFC_0000_0005);
    tick;
    chk("m3_wrap2_ovf", {47'd0, if3.P_OVF}, 48'd1);
    rst3 = 1'b1;
    tick;
    chk("m3_srst_p", if3.P, 48'd0);
    chk("m3_srst_ovf", {47'd0, if3.P_OVF}, 48'd0);
    rst3 = 1'b0;
    tick; chk("m3_post_rst0", if3.P, 48'd0);
    tick; chk("m3_post_rst_acc", if3.P, 48'h0004_0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mae_dsp_model.md
# mae_dsp_model

Cycle-accurate behavioural model of the MAE DSP slice, the primitive our DSP techmap flow instantiates. It is used in post-synthesis simulation and in equivalence benches to check that mapped netlists match RTL intent. The datapath is an 18x18 signed multiplier with optional input registers, an optional C operand register, a configurable post-adder/accumulator and an optional 48-bit output register.

## Interface
Parameters:
- BYPASS_A, 0, 1 = A input register bypassed (combinational); 0 = registered
- BYPASS_B, 0, same for B
- BYPASS_C, 0, same for C
- BYPASS_P, 0, same for P output register
- POST_ADDER, 0, 0 = product only; 1 = product + C; 2 = accumulate; 3 = accumulate with C preload
- POST_ADDER 2 or 3 with BYPASS_P=1 is an elaboration error ($error).

Ports:
- CLK  in  1  clock, all state on rising edge
- SRST  in  1  global reset; synchronous, active-high; overrides every other control
- A  in  18  signed multiplicand
- A_EN  in  1  A register (and ACC_LOAD pipe) load enable
- A_SRST_N  in  1  A register sync clear, active-low
- B  in  18  signed multiplier
- B_EN  in  1  B register load enable
- B_SRST_N  in  1  B register sync clear, active-low
- C  in  40  signed addend
- C_EN  in  1  C register load enable
- C_SRST_N  in  1  C register sync clear, active-low
- ACC_LOAD  in  1  restart accumulation with the accompanying A/B
- P_EN  in  1  P register / accumulator update enable
- P_SRST_N  in  1  P register sync clear, active-low
- P  out  48  signed result
- P_OVF  out  1  sticky signed-overflow flag (modes 2/3 only, else constant 0)

## Operation
- Register update priority, per register X in {A, B, C, P}: SRST=1 -> 0; else X_SRST_N=0 -> 0; else X_EN=1 -> load; else hold.
- A_int/B_int/C_int = register output, or the port directly when the matching BYPASS is 1.
- ACC_LOAD travels through a 1-bit register alongside A when BYPASS_A=0, using A's EN/SRST/SRST_N; when BYPASS_A=1 it is used directly. The aligned signal is LD.
- PROD = A_int * B_int, 36-bit signed, sign-extended to 48.
- Post-adder result S, computed in 48 bits with two's-complement wrap:
  - mode 0: S = PROD
  - mode 1: S = PROD + sext48(C_int)
  - mode 2: S = LD ? PROD : P_reg + PROD
  - mode 3: S = LD ? PROD + sext48(C_int) : P_reg + PROD
- P = P_reg when BYPASS_P=0, else S.
- P_OVF: set when a non-LD accumulate step has operands of equal sign and a result of differing sign, and P_EN=1. Cleared by SRST, by P_SRST_N=0, or by an LD step with P_EN=1. Otherwise holds.
- With P_EN=0 the accumulator and P_OVF hold regardless of LD; an LD presented then is lost.

## Timing
- Reset: every internal register, P and P_OVF read 0 after the first CLK edge with SRST=1. In fully bypassed mode 0/1, P follows the inputs combinationally even during SRST.
- Latency A/B to P = (BYPASS_A?0:1) + (BYPASS_P?0:1) cycles. A and B must share the same BYPASS setting for aligned operands; mismatched settings are modelled literally.
- C to P latency = (BYPASS_C?0:1) + (BYPASS_P?0:1).
- Back-to-back: one new product is accepted per cycle with enables high; there are no bubbles.
- SRST mid-accumulation: the next edge zeroes the pipeline and the accumulator. The first accumulate after release adds to 0 even without LD.
- Simultaneous P_SRST_N=0 and LD: the clear wins and P=0.

## Test plan
- All registered, mode 0: A=3, B=-4 at edge 0 -> P=0xFFFF_FFFF_FFF4 (-12) after edge 2; P=0 from reset before that.
- All bypassed, mode 1: A=100, B=200, C=-5 -> P=19995 combinationally. Change C to 5 -> P=20005 with no clock.
- Mode 2, registered: ACC_LOAD=1 with A=2, B=3, then three beats with ACC_LOAD=0 and the same operands -> P=6, 12, 18, 24 on consecutive cycles. Drop P_EN for one cycle -> P holds at 24.
- Mode 3 overflow: LD with A=-131072, B=-131072, C=0 (product 2^34), then 8191 accumulate beats -> P_OVF rises on the beat where P wraps to -2^47. P_OVF stays 1 until the next LD beat clears it.
- Resets: mid-accumulation assert SRST for one cycle -> P=0 and P_OVF=0 next edge. Then A_SRST_N=0 with A_EN=1 -> A register=0, so the next product is 0.
- Mode 2 with BYPASS_P=1 -> simulator reports an elaboration error.
